warp_fetch_sched: RTL

- Parametrised warp fetch scheduler. Accepts a batch mask of warps to fetch and issues one (warp id, PC) beat per selected warp on a back-pressured output stream.
- Selection is round-robin or fixed-priority, gated by a per-warp ready/stall mask.
- Sits between the warp scheduler/initialiser and the instruction fetch unit; the branch unit writes PC updates into its PC table.

---
 rtl/warp_fetch_sched.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/warp_fetch_sched.sv
// Warp fetch scheduler: issues one (slot, warp id, PC) beat per selected warp of a batch on a
// back-pressured stream, choosing round-robin or fixed priority among currently ready warps.
module warp_fetch_sched #(
    parameter int unsigned NUM_WARPS   = 32,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned WID_W       = 5,
    parameter int unsigned POLICY      = 0,
    parameter int unsigned STALL_LIMIT = 255,
    localparam int unsigned IDX_W      = $clog2(NUM_WARPS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       init,
    input  logic [NUM_WARPS*PC_W-1:0]  init_pc,
    input  logic [NUM_WARPS*WID_W-1:0] init_wid,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [NUM_WARPS-1:0]       s_mask,
    input  logic [NUM_WARPS-1:0]       warp_ready,
    input  logic                       pc_upd_valid,
    input  logic [IDX_W-1:0]           pc_upd_idx,
    input  logic [PC_W-1:0]            pc_upd_pc,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [IDX_W-1:0]           m_idx,
    output logic [WID_W-1:0]           m_wid,
    output logic [PC_W-1:0]            m_pc,
    output logic                       m_tlast,
    output logic [2:0]                 err
);

    localparam int unsigned CNT_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                 state_q, state_d;
    logic [NUM_WARPS-1:0]   pending_q, pending_d;
    logic [IDX_W-1:0]       last_idx_q, last_idx_d;
    logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
    logic [PC_W-1:0]        pc_tbl_q [NUM_WARPS];
    logic [PC_W-1:0]        pc_tbl_d [NUM_WARPS];
    logic [WID_W-1:0]       wid_tbl_q [NUM_WARPS];
    logic [WID_W-1:0]       wid_tbl_d [NUM_WARPS];
    logic                   s_tready_q, s_tready_d;
    logic                   m_tvalid_q, m_tvalid_d;
    logic [IDX_W-1:0]       m_idx_q, m_idx_d;
    logic [WID_W-1:0]       m_wid_q, m_wid_d;
    logic [PC_W-1:0]        m_pc_q, m_pc_d;
    logic                   m_tlast_q, m_tlast_d;
    logic [2:0]             err_q, err_d;

    logic [NUM_WARPS-1:0]   eligible_c;
    logic                   out_free_c;
    logic                   pick_found_c;
    logic [IDX_W-1:0]       pick_idx_c;

    assign eligible_c = pending_q & warp_ready;
    assign out_free_c = !m_tvalid_q || m_tready;

    // Round-robin searches upward from the slot after the last one issued, wrapping at NUM_WARPS.
    always_comb begin : pick_sel
        logic [IDX_W-1:0] cand;
        cand         = '0;
        pick_found_c = 1'b0;
        pick_idx_c   = '0;
        if (POLICY == 0) begin
            for (int unsigned i = 1; i <= NUM_WARPS; i++) begin
                cand = last_idx_q + IDX_W'(i);
                if (!pick_found_c && eligible_c[cand]) begin
                    pick_found_c = 1'b1;
                    pick_idx_c   = cand;
                end
            end
        end else begin
            for (int unsigned i = 0; i < NUM_WARPS; i++) begin
                if (!pick_found_c && eligible_c[IDX_W'(i)]) begin
                    pick_found_c = 1'b1;
                    pick_idx_c   = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin : next_state
        logic [NUM_WARPS-1:0] remain;
        remain      = pending_q & ~(NUM_WARPS'(1) << pick_idx_c);
        state_d     = state_q;
        pending_d   = pending_q;
        last_idx_d  = last_idx_q;
        stall_cnt_d = stall_cnt_q;
        pc_tbl_d    = pc_tbl_q;
        wid_tbl_d   = wid_tbl_q;
        m_tvalid_d  = m_tvalid_q;
        m_idx_d     = m_idx_q;
        m_wid_d     = m_wid_q;
        m_pc_d      = m_pc_q;
        m_tlast_d   = m_tlast_q;
        err_d       = '0;

        if (pc_upd_valid) begin
            pc_tbl_d[pc_upd_idx] = pc_upd_pc;
        end

        unique case (state_q)
            IDLE: begin
                if (s_tvalid && s_tready_q) begin
                    if (s_mask == '0) begin
                        err_d[0] = 1'b1;
                    end else begin
                        pending_d = s_mask;
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                if (pick_found_c && out_free_c) begin
                    m_tvalid_d  = 1'b1;
                    m_idx_d     = pick_idx_c;
                    m_wid_d     = wid_tbl_q[pick_idx_c];
                    m_pc_d      = (pc_upd_valid && pc_upd_idx == pick_idx_c) ? pc_upd_pc
                                                                             : pc_tbl_q[pick_idx_c];
                    m_tlast_d   = (remain == '0);
                    pending_d   = remain;
                    last_idx_d  = pick_idx_c;
                    stall_cnt_d = '0;
                end else if (out_free_c) begin
                    m_tvalid_d = 1'b0;
                end
                // Saturating stall counter: the timeout pulses once and the batch keeps waiting.
                if (STALL_LIMIT != 0 && pending_q != '0 && eligible_c == '0
                        && stall_cnt_q != CNT_W'(STALL_LIMIT)) begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                    if (stall_cnt_d == CNT_W'(STALL_LIMIT)) begin
                        err_d[2] = 1'b1;
                    end
                end
                if (pending_q == '0 && out_free_c) begin
                    state_d     = IDLE;
                    stall_cnt_d = '0;
                end
            end
            default: ;
        endcase

        if (init) begin
            for (int unsigned i = 0; i < NUM_WARPS; i++) begin
                pc_tbl_d[IDX_W'(i)]  = init_pc[i*PC_W +: PC_W];
                wid_tbl_d[IDX_W'(i)] = init_wid[i*WID_W +: WID_W];
            end
            pending_d   = '0;
            m_tvalid_d  = 1'b0;
            m_tlast_d   = 1'b0;
            state_d     = IDLE;
            last_idx_d  = IDX_W'(NUM_WARPS - 1);
            stall_cnt_d = '0;
            err_d       = '0;
            err_d[1]    = (state_q == BUSY);
        end

        s_tready_d = !init && (state_d == IDLE) && !m_tvalid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            last_idx_q  <= IDX_W'(NUM_WARPS - 1);
            stall_cnt_q <= '0;
            pc_tbl_q    <= '{default: '0};
            wid_tbl_q   <= '{default: '0};
            s_tready_q  <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_idx_q     <= '0;
            m_wid_q     <= '0;
            m_pc_q      <= '0;
            m_tlast_q   <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            last_idx_q  <= last_idx_d;
            stall_cnt_q <= stall_cnt_d;
            pc_tbl_q    <= pc_tbl_d;
            wid_tbl_q   <= wid_tbl_d;
            s_tready_q  <= s_tready_d;
            m_tvalid_q  <= m_tvalid_d;
            m_idx_q     <= m_idx_d;
            m_wid_q     <= m_wid_d;
            m_pc_q      <= m_pc_d;
            m_tlast_q   <= m_tlast_d;
            err_q       <= err_d;
        end
    end

    assign s_tready = s_tready_q;
    assign m_tvalid = m_tvalid_q;
    assign m_idx    = m_idx_q;
    assign m_wid    = m_wid_q;
    assign m_pc     = m_pc_q;
    assign m_tlast  = m_tlast_q;
    assign err      = err_q;

endmodule
